branch_predictor_btb: RTL
=========================

// Module: branch_predictor_btb
// PURPOSE
//  Parametrised branch target buffer with per-entry saturating counters.
//  Replaces the pipeline's fixed predict-not-taken fetch policy.
//  Sits beside the fetch PC register:
//   - fetch side: combinational lookup of i_pc_fetch gives the predicted next PC.
//   - execute side: resolved branches/jumps update the table; the block flags mispredicts and supplies the redirect PC.
// PARAMETERS
//  ENTRIES  32  table depth; power of two, >=2; IDX_W = $clog2(ENTRIES)
//  TAG_W    8   tag bits, taken from pc[IDX_W+2 +: TAG_W]; IDX_W+2+TAG_W <= 32
//  CNT_W    2   saturating counter width, >=1; predict taken when counter MSB = 1
// PORTS
//  i_clk              in   1   clock, rising edge
//  i_reset            in   1   reset, asynchronous, active-low
//  i_pc_fetch         in   32  PC being fetched this cycle
//  o_pred_taken       out  1   lookup predicts redirect
//  o_pred_target      out  32  predicted next PC (BTB target, else i_pc_fetch+4)
//  i_upd_vld          in   1   resolved instruction present in execute (not flushed)
//  i_upd_pc           in   32  PC of the resolved instruction
//  i_upd_is_br        in   1   conditional branch
//  i_upd_is_jmp       in   1   JAL/JALR
//  i_upd_taken        in   1   actual outcome (1 for jumps)
//  i_upd_target       in   32  actual target (ALU result)
//  i_upd_pred_taken   in   1   prediction made at fetch, piped with the instruction
//  i_upd_pred_target  in   32  predicted target, piped with the instruction
//  i_clear            in   1   sync invalidate all entries (fence.i / self-modifying code)
//  o_mispred          out  1   execute-stage mispredict; pipeline flushes decode+execute
//  o_redirect_pc      out  32  correct next PC when o_mispred = 1
//  o_br_cnt           out  32  resolved control-transfer count, saturating
//  o_mispred_cnt      out  32  mispredict count, saturating
// BEHAVIOUR
//  Reset (async, i_reset=0):
//   - All valid bits, counters, tags, targets and jmp flags = 0.
//   - o_br_cnt = 0, o_mispred_cnt = 0.
//   - Lookup outputs then give o_pred_taken = 0 and o_pred_target = i_pc_fetch+4.
//  Lookup (combinational, 0-cycle):
//   - idx = i_pc_fetch[IDX_W+1:2]; hit = valid[idx] & (tag[idx] == pc tag field).
//   - o_pred_taken = hit & (jmp[idx] | ctr[idx][CNT_W-1]).
//   - o_pred_target = o_pred_taken ? target[idx] : i_pc_fetch+4.
//  Resolution (combinational on update port; all terms gated by i_upd_vld):
//   - o_mispred = i_upd_vld & (i_upd_taken != i_upd_pred_taken
//       | (i_upd_taken & i_upd_target != i_upd_pred_target)).
//   - o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc+4.
//   - Non-control op (is_br = is_jmp = 0): i_upd_taken is treated as 0, so pred_taken = 1 is a mispredict.
//  Table update (rising edge, i_upd_vld = 1, uidx/utag from i_upd_pc):
//   - Control op, tag hit:
//     - counter +1 if taken, -1 if not, saturating at 0 and 2^CNT_W-1;
//     - target <= i_upd_target if taken; jmp <= i_upd_is_jmp.
//   - Control op, miss, taken: allocate (overwrite) the entry:
//     - valid = 1; tag, target, jmp written;
//     - ctr = 2^(CNT_W-1) (weakly taken).
//   - Control op, miss, not taken: no allocation.
//   - Non-control op, tag hit (alias): valid[uidx] <= 0.
//  i_clear: all valid bits <= 0 at the edge. It overrides a same-cycle update. Counters and stats are retained.
//  Same-cycle lookup and update of one index: lookup returns pre-edge contents (no bypass).
//  Stats, on the edge, each saturating at 32'hFFFF_FFFF (no wrap):
//   - o_br_cnt +1 when i_upd_vld & (is_br | is_jmp);
//   - o_mispred_cnt +1 when o_mispred.
//  Reset asserted mid-operation: state clears immediately; no partial update completes.
//  Table storage is flops (asynchronous read). ENTRIES*(TAG_W+32+CNT_W+2) bits.
// TESTING
//  - Cold lookup:
//    reset, i_pc_fetch=0x100 -> o_pred_taken=0, o_pred_target=0x104.
//  - Allocate and predict:
//    update pc=0x100 br taken target=0x40, pred_taken=0 -> o_mispred=1, redirect=0x40;
//    next cycle, lookup 0x100 -> pred_taken=1, target=0x40.
//  - Counter hysteresis, CNT_W=2:
//    after allocate, one not-taken -> ctr=01, lookup predicts not taken; three taken -> ctr=11 and holds.
//  - Alias eviction:
//    ENTRIES=32, allocate 0x100, then non-control update at 0x100 with pred_taken=1
//    -> o_mispred=1, redirect=0x104, entry invalid.
//  - JALR target change:
//    jmp at 0x200 resolves to 0x80, then to 0x90 with pred_target=0x80
//    -> o_mispred=1, redirect=0x90, stored target becomes 0x90.
//  - Clear, stats and reset:
//    i_clear with a simultaneous update -> no hits afterwards;
//    stats preloaded to 0xFFFF_FFFF hold;
//    async reset mid-update -> all outputs at reset values.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with per-entry saturating counters.
// Fetch side: 0-cycle lookup of the fetch PC gives the predicted next PC.
// Execute side: resolved control transfers train/allocate/evict entries,
// mispredicts are flagged with the correct redirect PC, and saturating
// resolved/mispredict statistics are kept.

// One BTB entry: valid, tag, target, jmp flag and saturating counter.
module btb_entry #(
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sel,
  input  logic              alloc,
  input  logic              train,
  input  logic              evict,
  input  logic              taken,
  input  logic              is_jmp,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [31:0]       tgt_in,
  output logic              vld,
  output logic              jmp,
  output logic [TAG_W-1:0]  tag,
  output logic              ctr_msb,
  output logic [31:0]       tgt
);
  localparam logic [CNT_W-1:0] CTR_WEAK = CNT_W'(1) << (CNT_W-1);
  localparam logic [CNT_W-1:0] CTR_MAX  = '1;

  logic [CNT_W-1:0] ctr;

  assign ctr_msb = ctr[CNT_W-1];

  // Entry state: clear wins over any same-cycle update; only valid drops on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      jmp <= 1'b0;
      tag <= '0;
      ctr <= '0;
      tgt <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (sel) begin
      if (alloc) begin
        vld <= 1'b1;
        tag <= tag_in;
        tgt <= tgt_in;
        jmp <= is_jmp;
        ctr <= CTR_WEAK;
      end else if (train) begin
        if (taken) begin
          if (ctr != CTR_MAX) ctr <= ctr + CNT_W'(1);
          tgt <= tgt_in;
        end else if (ctr != '0) begin
          ctr <= ctr - CNT_W'(1);
        end
        jmp <= is_jmp;
      end else if (evict) begin
        vld <= 1'b0;
      end
    end
  end
endmodule

module branch_predictor_btb #(
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_fetch,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_br,
  input  logic        i_upd_is_jmp,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  input  logic        i_clear,
  output logic        o_mispred,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]             vld, jmp, ctr_msb;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][31:0]       tgt;

  logic [IDX_W-1:0] fidx, uidx;
  logic [TAG_W-1:0] ftag, utag;
  logic             fhit, uhit;
  logic             ctrl, taken;
  logic             alloc, train, evict;
  logic [31:0]      br_cnt_q, mis_cnt_q;

  // Fetch-side lookup: reads the pre-edge table, no bypass from the update port.
  assign fidx          = i_pc_fetch[IDX_W+1:2];
  assign ftag          = i_pc_fetch[IDX_W+2 +: TAG_W];
  assign fhit          = vld[fidx] & (tag[fidx] == ftag);
  assign o_pred_taken  = fhit & (jmp[fidx] | ctr_msb[fidx]);
  assign o_pred_target = o_pred_taken ? tgt[fidx] : i_pc_fetch + 32'd4;

  // Resolution: a non-control op is treated as not taken, so a taken
  // prediction on it is a mispredict that redirects to pc+4.
  assign uidx          = i_upd_pc[IDX_W+1:2];
  assign utag          = i_upd_pc[IDX_W+2 +: TAG_W];
  assign uhit          = vld[uidx] & (tag[uidx] == utag);
  assign ctrl          = i_upd_is_br | i_upd_is_jmp;
  assign taken         = ctrl & i_upd_taken;
  assign o_mispred     = i_upd_vld & ((taken != i_upd_pred_taken) |
                                      (taken & (i_upd_target != i_upd_pred_target)));
  assign o_redirect_pc = taken ? i_upd_target : i_upd_pc + 32'd4;

  // Table write intent, broadcast to all entries; only uidx is selected.
  assign train = i_upd_vld & ctrl & uhit;
  assign alloc = i_upd_vld & ctrl & ~uhit & taken;
  assign evict = i_upd_vld & ~ctrl & uhit;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    btb_entry #(.TAG_W(TAG_W), .CNT_W(CNT_W)) u_ent (
      .clk     (i_clk),
      .reset   (i_reset),
      .clear   (i_clear),
      .sel     (uidx == IDX_W'(g)),
      .alloc   (alloc),
      .train   (train),
      .evict   (evict),
      .taken   (taken),
      .is_jmp  (i_upd_is_jmp),
      .tag_in  (utag),
      .tgt_in  (i_upd_target),
      .vld     (vld[g]),
      .jmp     (jmp[g]),
      .tag     (tag[g]),
      .ctr_msb (ctr_msb[g]),
      .tgt     (tgt[g])
    );
  end

  // Saturating statistics; they keep counting through i_clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (i_upd_vld && ctrl && br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (o_mispred && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;
endmodule
